hazard_control_unit: RTL

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_control_unit.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
//
// Pipeline hazard and debug-halt controller for a classic 5-stage core.
// Decides, every cycle, which pipeline registers advance, which receive a
// bubble, and whether the PC is written. Four operating modes:
//   RUN     (0) : normal flow; resolves branch flushes, load-use stalls,
//                 multi-cycle mul/div starts and debug halt requests.
//   MD_WAIT (1) : pipeline frozen while a mul/div completes, guarded by a
//                 watchdog that gives up after MD_TIMEOUT cycles.
//   DRAIN   (2) : fetch stopped, in-flight instructions retire for
//                 DRAIN_CYCLES advancing cycles before halting.
//   HALTED  (3) : core parked for the debugger until halt_req drops.
//
// Ports
//   clk, rst              : clock, asynchronous active-high reset
//   if_id_rs1/rs2         : source registers of the instruction in ID
//   id_ex_rd              : destination register of the instruction in EX
//   id_ex_mem_read        : EX instruction is a load
//   id_ex_muldiv          : EX instruction is a multi-cycle mul/div
//   muldiv_done           : mul/div result valid this cycle
//   ex_branch_taken       : EX resolved a taken branch/jump
//   halt_req              : level-sensitive debug halt request
//   stat_clr              : clears stall_cycles and md_timeout
//   pc_write, if_id_write, id_ex_write        : register enables
//   if_id_flush, id_ex_flush, ex_mem_bubble   : bubble insertion
//   halted                : high only in HALTED
//   md_timeout            : sticky mul/div watchdog flag
//   stall_cycles          : saturating count of PC-stalled cycles
//   state                 : current mode (encoding above)
//
// All control outputs are combinational from the current mode and inputs.
// ---------------------------------------------------------------------------
module hazard_control_unit #(
    parameter int MD_TIMEOUT   = 64,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  if_id_rs1,
    input  logic [4:0]  if_id_rs2,
    input  logic [4:0]  id_ex_rd,
    input  logic        id_ex_mem_read,
    input  logic        id_ex_muldiv,
    input  logic        muldiv_done,
    input  logic        ex_branch_taken,
    input  logic        halt_req,
    input  logic        stat_clr,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_bubble,
    output logic        halted,
    output logic        md_timeout,
    output logic [15:0] stall_cycles,
    output logic [1:0]  state
);

    // -----------------------------------------------------------------------
    // Mode encoding
    // -----------------------------------------------------------------------
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MD_WAIT = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_HALTED  = 2'd3;

    // Counters only ever need to reach (limit - 1); keep at least one bit so
    // degenerate limits of 1 still elaborate.
    localparam int WAIT_W  = (MD_TIMEOUT   > 1) ? $clog2(MD_TIMEOUT)   : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MD_TIMEOUT - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [15:0]        STALL_MAX  = 16'hFFFF;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    logic [1:0]         state_reg,        state_next;
    logic [WAIT_W-1:0]  wait_cnt_reg,     wait_cnt_next;
    logic [DRAIN_W-1:0] drain_cnt_reg,    drain_cnt_next;
    logic [15:0]        stall_cycles_reg, stall_cycles_next;
    logic               md_timeout_reg,   md_timeout_next;

    // Raised for the single cycle in which the watchdog expires.
    logic               md_timeout_set;

    // -----------------------------------------------------------------------
    // Load-use detection: compare EX destination against both ID sources.
    // x0 is hard-wired zero, so a load to x0 never creates a dependency.
    // -----------------------------------------------------------------------
    logic [4:0] src_regs [2];
    logic [1:0] src_match;
    logic       load_use;

    assign src_regs[0] = if_id_rs1;
    assign src_regs[1] = if_id_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
            assign src_match[gi] = (id_ex_rd == src_regs[gi]);
        end
    endgenerate

    assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) && (|src_match);

    // -----------------------------------------------------------------------
    // Control outputs and next-mode logic
    // -----------------------------------------------------------------------
    always_comb begin
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        id_ex_write    = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_bubble  = 1'b0;
        halted         = 1'b0;
        md_timeout_set = 1'b0;
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        drain_cnt_next = drain_cnt_reg;

        // While reset is held the registers are already forced to RUN; also
        // mask the input-driven decisions so the pipeline sees a clean
        // default control set for the whole reset interval.
        if (!rst) begin
            case (state_reg)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        // Wrong-path instructions in IF/ID and ID/EX die.
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (id_ex_muldiv) begin
                        if (!muldiv_done) begin
                            pc_write      = 1'b0;
                            if_id_write   = 1'b0;
                            id_ex_write   = 1'b0;
                            ex_mem_bubble = 1'b1;
                            state_next    = ST_MD_WAIT;
                            wait_cnt_next = '0;
                        end
                        // Single-cycle completion: nothing to hold back.
                    end else if (load_use) begin
                        // Hold PC and IF/ID one cycle, bubble into EX.
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end else if (halt_req) begin
                        state_next     = ST_DRAIN;
                        drain_cnt_next = '0;
                    end
                end

                ST_MD_WAIT: begin
                    // Only the mul/div handshake matters here; branch,
                    // load-use and halt are re-evaluated once back in RUN.
                    if (muldiv_done) begin
                        state_next = ST_RUN;
                    end else begin
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        id_ex_write   = 1'b0;
                        ex_mem_bubble = 1'b1;
                        if (wait_cnt_reg == WAIT_LAST) begin
                            md_timeout_set = 1'b1;
                            state_next     = ST_RUN;
                        end else begin
                            wait_cnt_next = wait_cnt_reg + 1'b1;
                        end
                    end
                end

                ST_DRAIN: begin
                    // A dropped halt_req is deliberately not examined: once
                    // draining starts it runs to completion.
                    if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        if (drain_cnt_reg == DRAIN_LAST) begin
                            state_next = ST_HALTED;
                        end else begin
                            drain_cnt_next = drain_cnt_reg + 1'b1;
                        end
                    end else if (load_use) begin
                        // The dependent instruction must wait; this cycle
                        // does not advance the drain.
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end else begin
                        pc_write    = 1'b0;
                        if_id_flush = 1'b1;
                        if (drain_cnt_reg == DRAIN_LAST) begin
                            state_next = ST_HALTED;
                        end else begin
                            drain_cnt_next = drain_cnt_reg + 1'b1;
                        end
                    end
                end

                ST_HALTED: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    halted      = 1'b1;
                    if (!halt_req) begin
                        state_next = ST_RUN;
                    end
                end

                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Statistics: stat_clr wins over increment and over watchdog set.
    // HALTED is a parked core, not a stall, so it is not counted.
    // -----------------------------------------------------------------------
    always_comb begin
        stall_cycles_next = stall_cycles_reg;
        md_timeout_next   = md_timeout_reg;

        if (stat_clr) begin
            stall_cycles_next = '0;
            md_timeout_next   = 1'b0;
        end else begin
            if (!pc_write && (state_reg != ST_HALTED) &&
                (stall_cycles_reg != STALL_MAX)) begin
                stall_cycles_next = stall_cycles_reg + 16'd1;
            end
            if (md_timeout_set) begin
                md_timeout_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_RUN;
            wait_cnt_reg     <= '0;
            drain_cnt_reg    <= '0;
            stall_cycles_reg <= '0;
            md_timeout_reg   <= 1'b0;
        end else begin
            state_reg        <= state_next;
            wait_cnt_reg     <= wait_cnt_next;
            drain_cnt_reg    <= drain_cnt_next;
            stall_cycles_reg <= stall_cycles_next;
            md_timeout_reg   <= md_timeout_next;
        end
    end

    assign state        = state_reg;
    assign stall_cycles = stall_cycles_reg;
    assign md_timeout   = md_timeout_reg;

endmodule
